sext_arbiter: RTL and testbench

- Shares one 8-to-16-bit sign-extension resource between two datapath requesters: requester 0 is the ALU immediate path and requester 1 is the branch-offset path.
- Arbitration is round-robin, and each requester uses a valid/ready handshake.
- Extended results are buffered in a small in-order FIFO and tagged with the requester that produced them.
- The block sits between instruction decode and the operand/PC-adder muxes.

---
 rtl/sext_pkg.sv | 15 +
 rtl/sext_core.sv | 14 +
 rtl/sext_arbiter.sv | 126 ++++++++++++
 tb/tb_sext_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sext_pkg.sv
// Shared constants and the FIFO entry type for the sign-extension arbiter.
package sext_pkg;

   localparam int unsigned SEXT_IN_W  = 8;
   localparam int unsigned SEXT_OUT_W = 16;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_BR  = 1'b1;

   typedef struct packed {
      logic                  src;
      logic [SEXT_OUT_W-1:0] data;
   } sext_entry_t;

endpackage

// File: rtl/sext_core.sv
// Combinational 8-to-16 style extender: sign-extends imm, or zero-extends when zext is set.
module sext_core #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 16
) (
   input  logic [IN_W-1:0]  imm,
   input  logic             zext,
   output logic [OUT_W-1:0] data
);

   assign data = zext ? {{(OUT_W-IN_W){1'b0}}, imm}
                      : {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

endmodule

// File: rtl/sext_arbiter.sv
// Round-robin arbiter sharing one extender between ALU-immediate and branch-offset requesters,
// with an in-order result FIFO. Define SEXT_ARBITER_ZEXT_EN to add per-request zero-extension.
module sext_arbiter
   import sext_pkg::*;
#(
   parameter int unsigned IN_W  = SEXT_IN_W,
   parameter int unsigned OUT_W = SEXT_OUT_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [IN_W-1:0]        req_imm0,
   input  logic [IN_W-1:0]        req_imm1,
`ifdef SEXT_ARBITER_ZEXT_EN
   input  logic                   req_zext0,
   input  logic                   req_zext1,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_src,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic             src;
      logic [OUT_W-1:0] data;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           last_q;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             rr_q;

   logic             space;
   logic             push;
   logic             pop;
   logic [1:0]       grant;
   logic             grant_idx;
   logic [IN_W-1:0]  sel_imm;
   logic             sel_zext;
   logic [OUT_W-1:0] ext_data;

   assign out_valid  = (count_q != '0);
   assign fifo_count = count_q;
   assign pop        = out_valid & out_ready;
   // A same-cycle pop frees the slot the push needs, so a full FIFO keeps streaming.
   assign space      = (count_q < CNT_W'(DEPTH)) | pop;

   always_comb begin
      req_ready = 2'b00;
      if (rst_n && space) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = (rr_q == REQ_BR) ? 2'b10 : 2'b01;
            default: req_ready = 2'b00;
         endcase
      end
   end

   assign grant     = req_valid & req_ready;
   assign push      = |grant;
   assign grant_idx = grant[1];

   // Mux before the single extender instance.
   assign sel_imm = (grant_idx == REQ_BR) ? req_imm1 : req_imm0;
`ifdef SEXT_ARBITER_ZEXT_EN
   assign sel_zext = (grant_idx == REQ_BR) ? req_zext1 : req_zext0;
`else
   assign sel_zext = 1'b0;
`endif

   sext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_sext_core (
      .imm  (sel_imm),
      .zext (sel_zext),
      .data (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_q     <= REQ_ALU;
         last_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            rr_q     <= ~grant_idx;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q];
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{src: grant_idx, data: ext_data};
      end
   end

   // When empty, present the last popped entry rather than a stale slot.
   assign head     = out_valid ? mem_q[rd_ptr_q] : last_q;
   assign out_data = head.data;
   assign out_src  = head.src;

endmodule

// File: tb/tb_sext_arbiter.sv
// Directed plus randomized bench for sext_arbiter against a queue-based reference model.
module tb_sext_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [7:0]  req_imm0 = 8'h00;
   logic [7:0]  req_imm1 = 8'h00;
   logic        req_zext0 = 1'b0;
   logic        req_zext1 = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_src;
   logic [1:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   logic [16:0] q[$];
   logic        rr_m = 1'b0;

   sext_arbiter #(
      .IN_W  (8),
      .OUT_W (16),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_imm0   (req_imm0),
      .req_imm1   (req_imm1),
`ifdef SEXT_ARBITER_ZEXT_EN
      .req_zext0  (req_zext0),
      .req_zext1  (req_zext1),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ext(input logic [7:0] imm, input logic z);
      if (z || imm < 8'd128) return {8'h00, imm};
      return 16'(32'(imm) + 32'hFF00);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One cycle: apply inputs after the falling edge, check, then advance the model.
   task automatic step(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1,
                       input logic z0, input logic z1, input logic o, input string tag);
      logic [1:0]  exp_grant;
      logic        room;
      logic        popm;
      logic        g;
      logic [16:0] dropped;
      @(negedge clk);
      req_valid = v;
      req_imm0  = i0;
      req_imm1  = i1;
      req_zext0 = z0;
      req_zext1 = z1;
      out_ready = o;
      #1;
      popm = (q.size() != 0) && o;
      room = (q.size() < DEPTH) || popm;
      exp_grant = 2'b00;
      if (room) begin
         if (v == 2'b01) exp_grant = 2'b01;
         else if (v == 2'b10) exp_grant = 2'b10;
         else if (v == 2'b11) exp_grant = rr_m ? 2'b10 : 2'b01;
      end
      chk({tag, ":grant"}, 32'(req_valid & req_ready), 32'(exp_grant));
      chk({tag, ":one_hot"}, 32'(&req_ready), 32'd0);
      chk({tag, ":count"}, 32'(fifo_count), 32'(q.size()));
      chk({tag, ":valid"}, 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, ":data"}, 32'(out_data), 32'(q[0][15:0]));
         chk({tag, ":src"}, 32'(out_src), 32'(q[0][16]));
      end
      if (popm) dropped = q.pop_front();
      if (exp_grant != 2'b00) begin
         g = exp_grant[1];
         q.push_back({g, ext(g ? i1 : i0, g ? z1 : z0)});
         rr_m = ~g;
      end
   endtask

   task automatic expect_head(input logic [15:0] d, input logic s, input string tag);
      @(posedge clk);
      #1;
      chk({tag, ":hvalid"}, 32'(out_valid), 32'd1);
      chk({tag, ":hdata"}, 32'(out_data), 32'(d));
      chk({tag, ":hsrc"}, 32'(out_src), 32'(s));
   endtask

   initial begin
      logic z0r;
      logic z1r;
      // Reset state, with requests pending to show ready stays low.
      req_valid = 2'b11;
      #1;
      chk("rst:valid", 32'(out_valid), 32'd0);
      chk("rst:count", 32'(fifo_count), 32'd0);
      chk("rst:data", 32'(out_data), 32'd0);
      chk("rst:src", 32'(out_src), 32'd0);
      chk("rst:ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b1;

      step(2'b01, 8'h85, 8'h00, 1'b0, 1'b0, 1'b0, "single");
      expect_head(16'hFF85, 1'b0, "single");
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "pop1");

      step(2'b10, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, "pos");
      expect_head(16'h007F, 1'b1, "pos");
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "pop2");

      for (int i = 0; i < 6; i++) step(2'b11, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, "rr");
      for (int i = 0; i < 3; i++) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "drain");

      for (int i = 0; i < 4; i++) step(2'b11, 8'h11, 8'hE2, 1'b0, 1'b0, 1'b0, "bp");
      chk("bp:full_count", 32'(fifo_count), 32'd2);
      chk("bp:full_ready", 32'(req_ready), 32'd0);
      step(2'b11, 8'h22, 8'hC3, 1'b0, 1'b0, 1'b1, "bp_swap");
      step(2'b11, 8'h33, 8'hA4, 1'b0, 1'b0, 1'b0, "bp_hold");

      // Asynchronous reset while full.
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst:valid", 32'(out_valid), 32'd0);
      chk("midrst:count", 32'(fifo_count), 32'd0);
      q.delete();
      rr_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(2'b11, 8'h40, 8'hBF, 1'b0, 1'b0, 1'b0, "postrst");
      chk("postrst:first", 32'(req_valid & req_ready), 32'd1);
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "postrst_drain");
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "postrst_drain");

`ifdef SEXT_ARBITER_ZEXT_EN
      step(2'b01, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, "zext1");
      expect_head(16'h00F0, 1'b0, "zext1");
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "zext_pop");
      step(2'b01, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, "zext0");
      expect_head(16'hFFF0, 1'b0, "zext0");
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "zext_pop");
`endif

      for (int i = 0; i < 400; i++) begin
`ifdef SEXT_ARBITER_ZEXT_EN
         z0r = 1'($urandom_range(0, 1));
         z1r = 1'($urandom_range(0, 1));
`else
         z0r = 1'b0;
         z1r = 1'b0;
`endif
         step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), z0r, z1r,
              $urandom_range(0, 2) != 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
